// File: rtl/hazard_unit.sv
// Hazard unit: load-use stall detection, taken-branch flush and HALT drain/resume sequencing.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_enable               pipeline advance enable; when low, state and counters hold
//   i_rs_if_id, i_rt_if_id source register fields of the ID instruction
//   i_uses_rt_if_id        ID instruction reads rt
//   i_rt_id_ex             destination rt of the EX instruction
//   i_mem_read_id_ex       EX instruction is a load
//   i_branch_taken_id      branch/jump resolved taken in ID
//   i_halt_id              HALT decoded in ID
//   i_resume               single-cycle pulse that leaves HALTED
//   o_pc_write             PC update enable
//   o_if_id_write          IF/ID load enable
//   o_ctrl_flush           inject bubble into ID/EX
//   o_if_id_flush          clear IF/ID to NOP
//   o_halted               registered halted indication
//   o_stall_count          saturating count of load-use stall cycles
module hazard_unit #(
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB_ADDR-1:0] i_rs_if_id,
    input  logic [NB_ADDR-1:0] i_rt_if_id,
    input  logic               i_uses_rt_if_id,
    input  logic [NB_ADDR-1:0] i_rt_id_ex,
    input  logic               i_mem_read_id_ex,
    input  logic               i_branch_taken_id,
    input  logic               i_halt_id,
    input  logic               i_resume,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic               o_ctrl_flush,
    output logic               o_if_id_flush,
    output logic               o_halted,
    output logic [NB_CNT-1:0]  o_stall_count
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    // HALT must travel EX, MEM and WB before the pipeline is considered empty.
    localparam logic [1:0] DrainCycles = 2'd3;

    state_e            state_q, state_d;
    logic [1:0]        drain_q, drain_d;
    logic [NB_CNT-1:0] stall_q, stall_d;
    logic              halted_q;
    logic              hz;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign hz = i_mem_read_id_ex && (i_rt_id_ex != '0) &&
                ((i_rt_id_ex == i_rs_if_id) ||
                 (i_uses_rt_if_id && (i_rt_id_ex == i_rt_if_id)));

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        stall_d       = stall_q;
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_ctrl_flush  = 1'b0;
        o_if_id_flush = 1'b0;

        if (i_enable) begin
            unique case (state_q)
                StRun: begin
                    // Priority hz > halt > branch; masked events are re-presented by the held ID.
                    if (hz) begin
                        o_ctrl_flush = 1'b1;
                        if (stall_q != '1) begin
                            stall_d = stall_q + NB_CNT'(1);
                        end
                    end else if (i_halt_id) begin
                        // Freeze fetch but let HALT itself advance into EX.
                        drain_d = DrainCycles;
                        state_d = StDrain;
                    end else begin
                        o_pc_write    = 1'b1;
                        o_if_id_write = 1'b1;
                        o_if_id_flush = i_branch_taken_id;
                    end
                end
                StDrain: begin
                    o_ctrl_flush = 1'b1;
                    drain_d      = drain_q - 2'd1;
                    if (drain_q == 2'd1) begin
                        state_d = StHalted;
                    end
                end
                StHalted: begin
                    o_ctrl_flush = 1'b1;
                    if (i_resume) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end

        if (i_reset) begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
            o_ctrl_flush  = 1'b0;
            o_if_id_flush = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StRun;
            drain_q  <= 2'd0;
            stall_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            stall_q  <= stall_d;
            halted_q <= (state_d == StHalted);
        end
    end

    assign o_halted      = halted_q;
    assign o_stall_count = stall_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    localparam int unsigned NB_ADDR = 5;
    localparam int unsigned NB_CNT  = 4;

    logic               i_clk = 1'b0;
    logic               i_reset;
    logic               i_enable;
    logic [NB_ADDR-1:0] i_rs_if_id;
    logic [NB_ADDR-1:0] i_rt_if_id;
    logic               i_uses_rt_if_id;
    logic [NB_ADDR-1:0] i_rt_id_ex;
    logic               i_mem_read_id_ex;
    logic               i_branch_taken_id;
    logic               i_halt_id;
    logic               i_resume;
    logic               o_pc_write;
    logic               o_if_id_write;
    logic               o_ctrl_flush;
    logic               o_if_id_flush;
    logic               o_halted;
    logic [NB_CNT-1:0]  o_stall_count;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.NB_ADDR(NB_ADDR), .NB_CNT(NB_CNT)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_enable         (i_enable),
        .i_rs_if_id       (i_rs_if_id),
        .i_rt_if_id       (i_rt_if_id),
        .i_uses_rt_if_id  (i_uses_rt_if_id),
        .i_rt_id_ex       (i_rt_id_ex),
        .i_mem_read_id_ex (i_mem_read_id_ex),
        .i_branch_taken_id(i_branch_taken_id),
        .i_halt_id        (i_halt_id),
        .i_resume         (i_resume),
        .o_pc_write       (o_pc_write),
        .o_if_id_write    (o_if_id_write),
        .o_ctrl_flush     (o_ctrl_flush),
        .o_if_id_flush    (o_if_id_flush),
        .o_halted         (o_halted),
        .o_stall_count    (o_stall_count)
    );

    always #5 i_clk = ~i_clk;

    // Control outputs packed as {pc_write, if_id_write, ctrl_flush, if_id_flush}.
    localparam logic [3:0] CtlRun   = 4'b1100;
    localparam logic [3:0] CtlStall = 4'b0010;
    localparam logic [3:0] CtlFrz   = 4'b0000;
    localparam logic [3:0] CtlBr    = 4'b1101;
    localparam logic [3:0] CtlDrain = 4'b0010;

    function automatic logic [3:0] ctl();
        return {o_pc_write, o_if_id_write, o_ctrl_flush, o_if_id_flush};
    endfunction

    // Advance one edge; inputs are changed and outputs sampled 1 time unit after posedge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_reset           = 1'b0;
        i_enable          = 1'b1;
        i_rs_if_id        = '0;
        i_rt_if_id        = '0;
        i_uses_rt_if_id   = 1'b0;
        i_rt_id_ex        = '0;
        i_mem_read_id_ex  = 1'b0;
        i_branch_taken_id = 1'b0;
        i_halt_id         = 1'b0;
        i_resume          = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        i_reset = 1'b1;
        i_enable = 1'b0;
        i_halt_id = 1'b1;
        #1;
        checks++;
        if (ctl() !== CtlRun) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", ctl(), CtlRun);
        end
        step();
        idle();
        checks++;
        if (o_stall_count !== 4'd0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: stall=%0d halted=%b expected 0/0", o_stall_count, o_halted);
        end
        checks++;
        if (ctl() !== CtlRun) begin
            errors++;
            $display("FAIL reset_run: got %b expected %b", ctl(), CtlRun);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        i_mem_read_id_ex = 1'b1;
        i_rt_id_ex = 5'd5;
        i_rs_if_id = 5'd5;
        #1;
        checks++;
        if (ctl() !== CtlStall) begin
            errors++;
            $display("FAIL load_use_ctl: got %b expected %b", ctl(), CtlStall);
        end
        step();
        idle();
        checks++;
        if (o_stall_count !== 4'd1 || ctl() !== CtlRun) begin
            errors++;
            $display("FAIL load_use_cnt: stall=%0d ctl=%b expected 1/%b", o_stall_count, ctl(),
                     CtlRun);
        end
        // Load to r0 never stalls.
        i_mem_read_id_ex = 1'b1;
        #1;
        checks++;
        if (ctl() !== CtlRun) begin
            errors++;
            $display("FAIL load_use_r0: got %b expected %b", ctl(), CtlRun);
        end
        step();
        checks++;
        if (o_stall_count !== 4'd1) begin
            errors++;
            $display("FAIL load_use_r0_cnt: got %0d expected 1", o_stall_count);
        end
        idle();
    endtask

    task automatic test_rt_match();
        idle();
        i_mem_read_id_ex = 1'b1;
        i_rt_id_ex = 5'd7;
        i_rt_if_id = 5'd7;
        i_rs_if_id = 5'd3;
        #1;
        checks++;
        if (ctl() !== CtlRun) begin
            errors++;
            $display("FAIL rt_no_use: got %b expected %b", ctl(), CtlRun);
        end
        i_uses_rt_if_id = 1'b1;
        #1;
        checks++;
        if (ctl() !== CtlStall) begin
            errors++;
            $display("FAIL rt_use: got %b expected %b", ctl(), CtlStall);
        end
        // Without a load there is no hazard even with matching registers.
        i_mem_read_id_ex = 1'b0;
        #1;
        checks++;
        if (ctl() !== CtlRun) begin
            errors++;
            $display("FAIL rt_no_load: got %b expected %b", ctl(), CtlRun);
        end
        idle();
    endtask

    task automatic test_branch();
        idle();
        i_branch_taken_id = 1'b1;
        #1;
        checks++;
        if (ctl() !== CtlBr) begin
            errors++;
            $display("FAIL branch: got %b expected %b", ctl(), CtlBr);
        end
        idle();
    endtask

    task automatic test_priority();
        do_reset();
        i_mem_read_id_ex = 1'b1;
        i_rt_id_ex = 5'd9;
        i_rs_if_id = 5'd9;
        i_branch_taken_id = 1'b1;
        i_halt_id = 1'b1;
        #1;
        checks++;
        if (ctl() !== CtlStall) begin
            errors++;
            $display("FAIL prio_all: got %b expected %b", ctl(), CtlStall);
        end
        step();
        idle();
        checks++;
        if (ctl() !== CtlRun || o_stall_count !== 4'd1) begin
            errors++;
            $display("FAIL prio_stay_run: ctl=%b stall=%0d expected %b/1", ctl(), o_stall_count,
                     CtlRun);
        end
        // Halt beats branch.
        i_halt_id = 1'b1;
        i_branch_taken_id = 1'b1;
        #1;
        checks++;
        if (ctl() !== CtlFrz) begin
            errors++;
            $display("FAIL prio_halt_branch: got %b expected %b", ctl(), CtlFrz);
        end
        idle();
    endtask

    task automatic test_halt();
        do_reset();
        i_resume = 1'b1;
        step();
        idle();
        checks++;
        if (ctl() !== CtlRun || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL resume_in_run: ctl=%b halted=%b expected %b/0", ctl(), o_halted, CtlRun);
        end
        i_halt_id = 1'b1;
        #1;
        checks++;
        if (ctl() !== CtlFrz) begin
            errors++;
            $display("FAIL halt_freeze: got %b expected %b", ctl(), CtlFrz);
        end
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            // Hazard and resume inputs are ignored while draining.
            i_mem_read_id_ex = 1'b1;
            i_rt_id_ex = 5'd4;
            i_rs_if_id = 5'd4;
            i_resume = 1'b1;
            #1;
            checks++;
            if (ctl() !== CtlDrain || o_halted !== 1'b0) begin
                errors++;
                $display("FAIL drain_%0d: ctl=%b halted=%b expected %b/0", i, ctl(), o_halted,
                         CtlDrain);
            end
            step();
            idle();
        end
        checks++;
        if (o_halted !== 1'b1 || ctl() !== CtlDrain || o_stall_count !== 4'd0) begin
            errors++;
            $display("FAIL halted: halted=%b ctl=%b stall=%0d expected 1/%b/0", o_halted, ctl(),
                     o_stall_count, CtlDrain);
        end
        i_branch_taken_id = 1'b1;
        step();
        idle();
        checks++;
        if (o_halted !== 1'b1) begin
            errors++;
            $display("FAIL halted_hold: got %b expected 1", o_halted);
        end
        i_resume = 1'b1;
        step();
        idle();
        checks++;
        if (o_halted !== 1'b0 || ctl() !== CtlRun) begin
            errors++;
            $display("FAIL resume: halted=%b ctl=%b expected 0/%b", o_halted, ctl(), CtlRun);
        end
    endtask

    task automatic test_enable_hold();
        int cyc;
        do_reset();
        // Disabled stall cycle must not count.
        i_enable = 1'b0;
        i_mem_read_id_ex = 1'b1;
        i_rt_id_ex = 5'd2;
        i_rs_if_id = 5'd2;
        #1;
        checks++;
        if (ctl() !== CtlFrz) begin
            errors++;
            $display("FAIL en0_ctl: got %b expected %b", ctl(), CtlFrz);
        end
        step();
        checks++;
        if (o_stall_count !== 4'd0) begin
            errors++;
            $display("FAIL en0_cnt: got %0d expected 0", o_stall_count);
        end
        idle();
        i_halt_id = 1'b1;
        step();
        idle();
        step();
        idle();
        i_enable = 1'b0;
        for (int i = 0; i < 5; i++) step();
        i_enable = 1'b1;
        // Two drain cycles remain after the pause.
        cyc = 0;
        while (o_halted !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL en0_drain: halted after %0d cycles expected 2", cyc);
        end
        idle();
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        do_reset();
        i_halt_id = 1'b1;
        step();
        idle();
        step();
        i_reset = 1'b1;
        i_enable = 1'b0;
        #1;
        checks++;
        if (ctl() !== CtlRun) begin
            errors++;
            $display("FAIL rst_drain_out: got %b expected %b", ctl(), CtlRun);
        end
        step();
        idle();
        checks++;
        if (ctl() !== CtlRun || o_halted !== 1'b0 || o_stall_count !== 4'd0) begin
            errors++;
            $display("FAIL rst_drain: ctl=%b halted=%b stall=%0d expected %b/0/0", ctl(), o_halted,
                     o_stall_count, CtlRun);
        end
        // A fresh HALT still takes the full three drain cycles.
        i_halt_id = 1'b1;
        step();
        idle();
        cyc = 0;
        while (o_halted !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL rst_redrain: halted after %0d cycles expected 3", cyc);
        end
        idle();
    endtask

    task automatic test_saturate();
        do_reset();
        i_mem_read_id_ex = 1'b1;
        i_rt_id_ex = 5'd31;
        i_rs_if_id = 5'd31;
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (o_stall_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_reach: got %0d expected 15", o_stall_count);
        end
        step();
        step();
        checks++;
        if (o_stall_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d expected 15", o_stall_count);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rt_match();
        test_branch();
        test_priority();
        test_halt();
        test_enable_hold();
        test_reset_mid_drain();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
